// File: rtl/seg_scan_arbiter.sv
// Frame-granular arbiter and 6-digit 7-segment scan driver shared by two requesters (H, F).
// Optional anti-ghosting blanking at the start of each digit slot: define BLANK_GAP_EN.
module seg_scan_arbiter #(
  parameter int SCAN_DIV    = 1000,
  parameter int HOLD_FRAMES = 4,
  parameter int BLANK_CYC   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        h_req_i,
  input  logic        f_req_i,
  input  logic [47:0] h_digits_i,
  input  logic [47:0] f_digits_i,
  output logic [5:0]  seg_com_o,
  output logic [7:0]  seg_data_o,
  output logic        v_sel_o,
  output logic        h_gnt_o,
  output logic        f_gnt_o,
  output logic        frame_tick_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_SHOW_F = 2'd1,
    ST_SHOW_H = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [47:0]   shadow_q, shadow_d;
  logic [5:0]    seg_com_q, seg_com_d;
  logic [7:0]    seg_data_q, seg_data_d;
  logic          v_sel_q, v_sel_d;
  logic          h_gnt_q, h_gnt_d;
  logic          f_gnt_q, f_gnt_d;
  logic          frame_tick_q, frame_tick_d;

  logic          slot_end;
  logic          boundary;
  logic          hold_done;
  logic          in_gap;
  logic [7:0]    digit_seg [6];
  logic [5:0]    com_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      assign digit_seg[gi] = shadow_q[8*gi +: 8];
      assign com_sel[gi]   = (digit_q != 3'(gi));
    end
  endgenerate

  assign slot_end = (presc_q == PW'(SCAN_DIV - 1));
  assign boundary = slot_end && (digit_q == 3'd5);
  // The frame ending at this boundary counts toward the hold, so a grant
  // yields after exactly HOLD_FRAMES completed frames.
  assign hold_done = (hold_q >= HW'(HOLD_FRAMES - 1));

`ifdef BLANK_GAP_EN
  assign in_gap = (presc_q < PW'(BLANK_CYC));
`else
  assign in_gap = 1'b0;
`endif

  always_comb begin
    presc_d  = slot_end ? '0 : presc_q + 1'b1;
    digit_d  = digit_q;
    state_d  = state_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;

    if (slot_end) begin
      digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
    end

    if (boundary) begin
      case (state_q)
        ST_BLANK: begin
          if (f_req_i)      state_d = ST_SHOW_F;
          else if (h_req_i) state_d = ST_SHOW_H;
        end
        ST_SHOW_F: begin
          if (h_req_i && (hold_done || !f_req_i)) state_d = ST_SHOW_H;
          else if (!f_req_i)                      state_d = ST_BLANK;
        end
        ST_SHOW_H: begin
          if (f_req_i && (hold_done || !h_req_i)) state_d = ST_SHOW_F;
          else if (!h_req_i)                      state_d = ST_BLANK;
        end
        default: state_d = ST_BLANK;
      endcase

      if (state_d != state_q)               hold_d = '0;
      else if (hold_q < HW'(HOLD_FRAMES))   hold_d = hold_q + 1'b1;

      // Latch the incoming owner's data so the whole next frame is tear-free.
      case (state_d)
        ST_SHOW_F: shadow_d = f_digits_i;
        ST_SHOW_H: shadow_d = h_digits_i;
        default:   shadow_d = '0;
      endcase
    end

    seg_com_d  = 6'b111111;
    seg_data_d = 8'h00;
    if (state_q != ST_BLANK && !in_gap) begin
      seg_com_d  = com_sel;
      seg_data_d = digit_seg[digit_q];
    end

    v_sel_d      = (state_q == ST_SHOW_H);
    h_gnt_d      = (state_q == ST_SHOW_H);
    f_gnt_d      = (state_q == ST_SHOW_F);
    frame_tick_d = boundary;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_BLANK;
      presc_q      <= '0;
      digit_q      <= '0;
      hold_q       <= '0;
      shadow_q     <= '0;
      seg_com_q    <= 6'b111111;
      seg_data_q   <= 8'h00;
      v_sel_q      <= 1'b0;
      h_gnt_q      <= 1'b0;
      f_gnt_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      hold_q       <= hold_d;
      shadow_q     <= shadow_d;
      seg_com_q    <= seg_com_d;
      seg_data_q   <= seg_data_d;
      v_sel_q      <= v_sel_d;
      h_gnt_q      <= h_gnt_d;
      f_gnt_q      <= f_gnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_com_o    = seg_com_q;
  assign seg_data_o   = seg_data_q;
  assign v_sel_o      = v_sel_q;
  assign h_gnt_o      = h_gnt_q;
  assign f_gnt_o      = f_gnt_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Bench for seg_scan_arbiter: directed test-plan steps followed by random requests,
// checked every cycle against a frame-level ownership model.
module tb_seg_scan_arbiter;
  localparam int SD = 4;
  localparam int HF = 2;
  localparam int BC = 1;
  localparam int FR = 6 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        h_req = 1'b0;
  logic        f_req = 1'b0;
  logic [47:0] h_dig = '0;
  logic [47:0] f_dig = '0;
  logic [5:0]  seg_com;
  logic [7:0]  seg_data;
  logic        v_sel, h_gnt, f_gnt, frame_tick;

  always #5 clk = ~clk;

  seg_scan_arbiter #(.SCAN_DIV(SD), .HOLD_FRAMES(HF), .BLANK_CYC(BC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .h_req_i(h_req), .f_req_i(f_req),
    .h_digits_i(h_dig), .f_digits_i(f_dig),
    .seg_com_o(seg_com), .seg_data_o(seg_data), .v_sel_o(v_sel),
    .h_gnt_o(h_gnt), .f_gnt_o(f_gnt), .frame_tick_o(frame_tick)
  );

  int checks = 0;
  int errors = 0;

  // Model: edges since reset release, owner (0 none, 1 F, 2 H), frames held, latched frame data
  int          e = 0;
  int          owner = 0;
  int          held = 0;
  logic [47:0] shadow = '0;
  logic [5:0]  x_com;
  logic [7:0]  x_data;
  logic        x_h, x_f, x_tick;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s e=%0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  function automatic bit gap(input int pr);
`ifdef BLANK_GAP_EN
    return pr < BC;
`else
    return pr < 0;
`endif
  endfunction

  task automatic decide(input logic hr, input logic fr);
    int  nxt;
    logic cur, oth;
    held++;
    nxt = owner;
    if (owner == 0) begin
      nxt = fr ? 1 : (hr ? 2 : 0);
    end else begin
      cur = (owner == 1) ? fr : hr;
      oth = (owner == 1) ? hr : fr;
      if (oth && (held >= HF || !cur)) nxt = 3 - owner;
      else if (!cur)                   nxt = 0;
    end
    if (nxt != owner) held = 0;
    owner  = nxt;
    shadow = (nxt == 1) ? f_dig : (nxt == 2) ? h_dig : 48'h0;
  endtask

  task automatic step();
    int p, pr, dg;
    @(posedge clk);
    e++;
    p  = e - 1;
    pr = p % SD;
    dg = (p / SD) % 6;
    x_tick = (e % FR == 0);
    x_h = (owner == 2);
    x_f = (owner == 1);
    if (owner == 0 || gap(pr)) begin
      x_com  = 6'h3F;
      x_data = 8'h00;
    end else begin
      x_com  = ~(6'd1 << dg);
      x_data = 8'(shadow >> (8 * dg));
    end
    if (e % FR == 0) decide(h_req, f_req);
    @(negedge clk);
    chk("seg_com", 64'(seg_com), 64'(x_com));
    chk("seg_data", 64'(seg_data), 64'(x_data));
    chk("v_sel", 64'(v_sel), 64'(x_h));
    chk("h_gnt", 64'(h_gnt), 64'(x_h));
    chk("f_gnt", 64'(f_gnt), 64'(x_f));
    chk("frame_tick", 64'(frame_tick), 64'(x_tick));
    chk("gnt_exclusive", 64'(h_gnt & f_gnt), 64'd0);
    chk("com_onecold", 64'($countones(~seg_com) <= 1), 64'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_com"}, 64'(seg_com), 64'h3F);
    chk({tag, "_data"}, 64'(seg_data), 64'h0);
    chk({tag, "_vsel"}, 64'(v_sel), 64'h0);
    chk({tag, "_hgnt"}, 64'(h_gnt), 64'h0);
    chk({tag, "_fgnt"}, 64'(f_gnt), 64'h0);
    chk({tag, "_tick"}, 64'(frame_tick), 64'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0; owner = 0; held = 0; shadow = '0;
  endtask

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    release_reset();

    // Idle: three blank frames with ticks
    run(72);

    // F takes the display at the next boundary
    f_req = 1'b1;
    f_dig = 48'h3F065B4F666D;
    h_dig = {16'($urandom), $urandom};
    run(25);
    $display("e=%0d F first digit: com=%b data=%h f_gnt=%b", e, seg_com, seg_data, f_gnt);
    chk("tp_f_com0", 64'(seg_com), 64'b111110);
    chk("tp_f_data0", 64'(seg_data), 64'h6D);
    chk("tp_f_gnt", 64'(f_gnt), 64'd1);

    // H competes from the start of F's first frame
    h_req = 1'b1;
    run(13);
    f_dig = 48'h0;
    run(11);
    chk("tp_tearfree_data", 64'(seg_data), 64'h00);
    chk("tp_still_f", 64'(f_gnt), 64'd1);
    run(24);
    $display("e=%0d after hold: v_sel=%b h_gnt=%b f_gnt=%b", e, v_sel, h_gnt, f_gnt);
    chk("tp_h_after_hold", 64'(h_gnt), 64'd1);
    chk("tp_vsel_after_hold", 64'(v_sel), 64'd1);

    // H drops mid-frame with no F request -> blank after frame end
    f_req = 1'b0;
    run(32);
    h_req = 1'b0;
    run(16);
    $display("e=%0d after H drop: com=%b h_gnt=%b", e, seg_com, h_gnt);
    chk("tp_blank_com", 64'(seg_com), 64'h3F);
    chk("tp_blank_hgnt", 64'(h_gnt), 64'd0);

    // H again, then asynchronous reset during digit 3
    h_req = 1'b1;
    run(37);
    chk("tp_h_digit3", 64'(seg_com), 64'b110111);
    rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    $display("e=%0d mid-digit reset: com=%b data=%h v_sel=%b", e, seg_com, seg_data, v_sel);
    release_reset();
    run(24);
    chk("tp_no_gnt_before_bnd", 64'(h_gnt), 64'd0);
    run(1);
    chk("tp_gnt_at_bnd", 64'(h_gnt), 64'd1);

    // Random requests and data changes
    for (int i = 0; i < 30 * FR; i++) begin
      if ($urandom_range(39) == 0) h_req = ~h_req;
      if ($urandom_range(39) == 0) f_req = ~f_req;
      if ($urandom_range(29) == 0) h_dig = {16'($urandom), $urandom};
      if ($urandom_range(29) == 0) f_dig = {16'($urandom), $urandom};
      step();
      if (e % FR == 1)
        $display("e=%0d frame start: owner=%0d h_req=%b f_req=%b com=%b data=%h", e, owner, h_req, f_req, seg_com, seg_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
